speed_control: RTL and testbench

- Upstream conditioner for the logo motion engine. Takes the raw inc_vel/dec_vel push-buttons and synchronises and debounces them.
- Turns each button into press/auto-repeat events that adjust a saturating velocity level.
- Emits a one-cycle move_tick whose rate follows that level. The logo block consumes vel and move_tick instead of raw buttons.

---
 rtl/speed_pkg.sv | 26 ++
 rtl/button_conditioner.sv | 64 ++++++
 rtl/speed_control.sv | 83 ++++++++
 tb/tb_speed_control.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Shared constants for the velocity conditioner and the logo motion engine.
// Cycle counts are derived from the 12 MHz system clock.
package speed_pkg;

  localparam int CLK_HZ        = 12_000_000;
  localparam int VEL_W         = 3;
  localparam int VEL_MAX       = 7;
  localparam int VEL_RESET     = 2;
  localparam int DB_CYCLES     = CLK_HZ / 100;      // 10 ms
  localparam int REPEAT_CYCLES = CLK_HZ / 10 * 3;   // 300 ms
  localparam int BASE_DIV      = 50_000;

  typedef enum logic [1:0] {
    VEL_HOLD,
    VEL_INC,
    VEL_DEC
  } vel_step_e;

  // Simultaneous inc and dec events cancel out.
  function automatic vel_step_e decode_step(input logic inc_ev, input logic dec_ev);
    if (inc_ev && !dec_ev)      return VEL_INC;
    else if (dec_ev && !inc_ev) return VEL_DEC;
    else                        return VEL_HOLD;
  endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronises and debounces one raw button and turns it into
// press / auto-repeat events (one-cycle, registered).
module button_conditioner #(
  parameter int DB_CYCLES     = speed_pkg::DB_CYCLES,
  parameter int REPEAT_CYCLES = speed_pkg::REPEAT_CYCLES
) (
  input  logic clk,
  input  logic clr,
  input  logic btn_i,
  output logic event_o
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic            ev_q, ev_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    deb_d     = deb_q;
    db_cnt_d  = '0;
    ev_d      = 1'b0;
    rep_cnt_d = '0;

    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) deb_d = sync2_q;
      else                                  db_cnt_d = db_cnt_q + DB_W'(1);
    end

    // Press fires on the accepting edge; repeats every REPEAT_CYCLES after it.
    if (deb_d && !deb_q) begin
      ev_d = 1'b1;
    end else if (deb_d) begin
      if (rep_cnt_q == RP_W'(REPEAT_CYCLES - 1)) ev_d = 1'b1;
      else                                       rep_cnt_d = rep_cnt_q + RP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      db_cnt_q  <= '0;
      rep_cnt_q <= '0;
      ev_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      db_cnt_q  <= db_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      ev_q      <= ev_d;
    end
  end

  assign event_o = ev_q;

endmodule

// File: rtl/speed_control.sv
// Velocity level register and move_tick divider fed by two conditioned
// push-buttons; all outputs are registered.
module speed_control #(
  parameter int VEL_W         = speed_pkg::VEL_W,
  parameter int VEL_MAX       = speed_pkg::VEL_MAX,
  parameter int VEL_RESET     = speed_pkg::VEL_RESET,
  parameter int DB_CYCLES     = speed_pkg::DB_CYCLES,
  parameter int REPEAT_CYCLES = speed_pkg::REPEAT_CYCLES,
  parameter int BASE_DIV      = speed_pkg::BASE_DIV
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc_vel,
  input  logic             dec_vel,
  output logic [VEL_W-1:0] vel,
  output logic             move_tick,
  output logic             vel_changed,
  output logic             at_limit
);

  import speed_pkg::*;

  localparam int   PER_W       = $clog2(BASE_DIV * (VEL_MAX + 1) + 1);
  localparam logic LIMIT_RESET = (VEL_RESET == 0) || (VEL_RESET == VEL_MAX);

  logic             inc_ev, dec_ev;
  logic [VEL_W-1:0] vel_q, vel_d;
  logic             changed_q, tick_q, tick_d, limit_q;
  logic [PER_W-1:0] per_d, div_cnt_q, div_cnt_d;

  button_conditioner #(.DB_CYCLES(DB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_inc (
    .clk    (clk),
    .clr    (clr),
    .btn_i  (inc_vel),
    .event_o(inc_ev)
  );

  button_conditioner #(.DB_CYCLES(DB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES)) u_dec (
    .clk    (clk),
    .clr    (clr),
    .btn_i  (dec_vel),
    .event_o(dec_ev)
  );

  always_comb begin
    vel_d = vel_q;
    unique case (decode_step(inc_ev, dec_ev))
      VEL_INC: if (vel_q < VEL_W'(VEL_MAX)) vel_d = vel_q + VEL_W'(1);
      VEL_DEC: if (vel_q != '0)             vel_d = vel_q - VEL_W'(1);
      default: ;
    endcase

    // Period of the level that will be visible next cycle; the divider
    // restarts from 0 whenever the level changes.
    per_d = PER_W'(BASE_DIV) * (PER_W'(VEL_MAX + 1) - PER_W'(vel_d));
    if (vel_d == '0 || vel_d != vel_q)            div_cnt_d = '0;
    else if (div_cnt_q == per_d - PER_W'(1))      div_cnt_d = '0;
    else                                          div_cnt_d = div_cnt_q + PER_W'(1);
    tick_d = (vel_d != '0) && (div_cnt_d == per_d - PER_W'(1));
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      vel_q     <= VEL_W'(VEL_RESET);
      changed_q <= 1'b0;
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
      limit_q   <= LIMIT_RESET;
    end else begin
      vel_q     <= vel_d;
      changed_q <= (vel_d != vel_q);
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
      limit_q   <= (vel_d == '0) || (vel_d == VEL_W'(VEL_MAX));
    end
  end

  assign vel         = vel_q;
  assign vel_changed = changed_q;
  assign move_tick   = tick_q;
  assign at_limit    = limit_q;

endmodule

// File: tb/tb_speed_control.sv
// Self-checking bench for speed_control with short cycle counts; a
// behavioural model predicts every output each cycle.
module tb_speed_control;

  localparam int VW   = 3;
  localparam int VMAX = 7;
  localparam int VR   = 2;
  localparam int DB   = 4;
  localparam int RP   = 20;
  localparam int BD   = 3;

  logic          clk = 1'b0;
  logic          clr, inc_vel, dec_vel;
  logic [VW-1:0] vel;
  logic          move_tick, vel_changed, at_limit;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  speed_control #(
    .VEL_W(VW), .VEL_MAX(VMAX), .VEL_RESET(VR),
    .DB_CYCLES(DB), .REPEAT_CYCLES(RP), .BASE_DIV(BD)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .inc_vel    (inc_vel),
    .dec_vel    (dec_vel),
    .vel        (vel),
    .move_tick  (move_tick),
    .vel_changed(vel_changed),
    .at_limit   (at_limit)
  );

  always #5 clk = ~clk;

  // Behavioural model: button level seen two cycles late, accepted once it
  // has disagreed with the accepted level for DB cycles in a row; events on
  // acceptance and every RP cycles of holding; vel applied a cycle later;
  // ticks when the age of the current level is P-1 modulo P.
  int       m_vel, m_age;
  bit       m_changed, m_limit, m_tick;
  bit       m_s1[2], m_s2[2], m_deb[2], m_ev[2];
  int       m_run[2], m_held[2];
  logic [5:0] m_out;

  task automatic model_edge(input bit c, input bit inc, input bit dec);
    int nv, per;
    bit raw, prev, nev;
    if (c) begin
      m_vel = VR; m_changed = 0; m_age = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0; m_ev[b] = 0;
        m_run[b] = 0; m_held[b] = 0;
      end
    end else begin
      nv = m_vel;
      if (m_ev[0] && !m_ev[1] && m_vel < VMAX) nv = m_vel + 1;
      else if (m_ev[1] && !m_ev[0] && m_vel > 0) nv = m_vel - 1;
      m_changed = (nv != m_vel);
      m_age     = m_changed ? 0 : m_age + 1;
      m_vel     = nv;
      for (int b = 0; b < 2; b++) begin
        raw  = (b == 0) ? inc : dec;
        prev = m_deb[b];
        nev  = 0;
        if (m_s2[b] != m_deb[b]) begin
          m_run[b]++;
          if (m_run[b] == DB) begin m_deb[b] = m_s2[b]; m_run[b] = 0; end
        end else m_run[b] = 0;
        if (m_deb[b] && !prev) begin nev = 1; m_held[b] = 0; end
        else if (m_deb[b]) begin m_held[b]++; if (m_held[b] % RP == 0) nev = 1; end
        else m_held[b] = 0;
        m_s2[b] = m_s1[b]; m_s1[b] = raw; m_ev[b] = nev;
      end
    end
    m_limit = (m_vel == 0) || (m_vel == VMAX);
    per     = BD * (VMAX + 1 - m_vel);
    m_tick  = (m_vel != 0) && ((m_age % per) == per - 1);
    m_out   = {3'(m_vel), m_changed, m_limit, m_tick};
  endtask

  task automatic tick_cycle();
    bit c, i, d;
    c = clr; i = inc_vel; d = dec_vel;
    @(posedge clk);
    model_edge(c, i, d);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    int first_t = -1, second_t = -1, chg = 0;
    clr = 1; inc_vel = 0; dec_vel = 0;
    tick_cycle();
    clr = 0;
    if ({vel, vel_changed, at_limit, move_tick} !== 6'b010_0_0_0) begin
      errors++; $display("FAIL reset_state got %b want %b", {vel, vel_changed, at_limit, move_tick}, 6'b010000);
    end
    checks++;
    for (int k = 1; k <= 60; k++) begin
      tick_cycle();
      if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
        errors++; $display("FAIL reset_run cyc=%0d got vel/chg/lim/tick=%b want %b", cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
      end
      checks++;
      if (vel_changed) chg++;
      if (move_tick) begin
        if (first_t < 0) first_t = k; else if (second_t < 0) second_t = k;
      end
    end
    if (first_t !== 17 || second_t !== 35) begin
      errors++; $display("FAIL reset_tick_times got %0d,%0d want 17,35", first_t, second_t);
    end
    checks++;
    if (chg !== 0) begin errors++; $display("FAIL reset_no_change got %0d pulses want 0", chg); end
    checks++;
  endtask

  task automatic test_short_press();
    int chg = 0, last_t = -1, gap = 0;
    for (int k = 0; k < 90; k++) begin
      inc_vel = (k < 3) || (k >= 30 && k < 40);
      tick_cycle();
      if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
        errors++; $display("FAIL short_press cyc=%0d got vel/chg/lim/tick=%b want %b", cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
      end
      checks++;
      if (vel_changed) chg++;
      if (move_tick) begin if (last_t >= 0) gap = k - last_t; last_t = k; end
    end
    if (chg !== 1 || vel !== 3'd3) begin
      errors++; $display("FAIL short_press_result got pulses=%0d vel=%0d want 1,3", chg, vel);
    end
    checks++;
    if (gap !== 15) begin errors++; $display("FAIL short_press_period got %0d want 15", gap); end
    checks++;
  endtask

  task automatic test_hold_inc();
    int chg_at[$];
    int chg_val[$];
    int last_t = -1, gap = 0;
    for (int k = 0; k < 230; k++) begin
      inc_vel = (k < 200);
      tick_cycle();
      if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
        errors++; $display("FAIL hold_inc cyc=%0d got vel/chg/lim/tick=%b want %b", cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
      end
      checks++;
      if (vel_changed) begin chg_at.push_back(k); chg_val.push_back(int'(vel)); end
      if (move_tick) begin if (last_t >= 0) gap = k - last_t; last_t = k; end
    end
    if (chg_at.size() !== 4) begin
      errors++; $display("FAIL hold_inc_steps got %0d changes want 4", chg_at.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (chg_val[i] !== 4 + i) begin errors++; $display("FAIL hold_inc_value[%0d] got %0d want %0d", i, chg_val[i], 4 + i); end
        checks++;
        if (i > 0 && chg_at[i] - chg_at[i-1] !== RP) begin
          errors++; $display("FAIL hold_inc_interval[%0d] got %0d want %0d", i, chg_at[i] - chg_at[i-1], RP);
        end
        if (i > 0) checks++;
      end
    end
    checks++;
    if (vel !== 3'd7 || at_limit !== 1'b1) begin
      errors++; $display("FAIL hold_inc_limit got vel=%0d lim=%b want 7,1", vel, at_limit);
    end
    checks++;
    if (gap !== 3) begin errors++; $display("FAIL hold_inc_period got %0d want 3", gap); end
    checks++;
    inc_vel = 0;
  endtask

  task automatic test_dec_to_zero();
    int k = 0, ticks = 0, last_t = -1, gap = 0;
    dec_vel = 1;
    while (vel !== 3'd0 && k < 300) begin
      tick_cycle();
      if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
        errors++; $display("FAIL dec_zero cyc=%0d got vel/chg/lim/tick=%b want %b", cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
      end
      checks++;
      k++;
    end
    dec_vel = 0;
    if (vel !== 3'd0) begin errors++; $display("FAIL dec_zero_timeout got vel=%0d want 0", vel); end
    checks++;
    for (int j = 0; j < 60; j++) begin
      tick_cycle();
      if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
        errors++; $display("FAIL dec_zero_idle cyc=%0d got vel/chg/lim/tick=%b want %b", cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
      end
      checks++;
      if (move_tick) ticks++;
    end
    if (ticks !== 0 || at_limit !== 1'b1) begin
      errors++; $display("FAIL dec_zero_stall got ticks=%0d lim=%b want 0,1", ticks, at_limit);
    end
    checks++;
    for (int j = 0; j < 80; j++) begin
      inc_vel = (j < 10);
      tick_cycle();
      if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
        errors++; $display("FAIL dec_zero_resume cyc=%0d got vel/chg/lim/tick=%b want %b", cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
      end
      checks++;
      if (move_tick) begin if (last_t >= 0) gap = j - last_t; last_t = j; end
    end
    if (vel !== 3'd1 || gap !== 21) begin
      errors++; $display("FAIL dec_zero_resume_period got vel=%0d gap=%0d want 1,21", vel, gap);
    end
    checks++;
  endtask

  task automatic test_both_buttons();
    int chg = 0;
    for (int k = 0; k < 75; k++) begin
      inc_vel = (k % 25) < 10;
      tick_cycle();
      if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
        errors++; $display("FAIL both_setup cyc=%0d got vel/chg/lim/tick=%b want %b", cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
      end
      checks++;
    end
    if (vel !== 3'd4) begin errors++; $display("FAIL both_setup_vel got %0d want 4", vel); end
    checks++;
    for (int k = 0; k < 40; k++) begin
      inc_vel = (k < 10); dec_vel = (k < 10);
      tick_cycle();
      if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
        errors++; $display("FAIL both_press cyc=%0d got vel/chg/lim/tick=%b want %b", cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
      end
      checks++;
      if (vel_changed) chg++;
    end
    if (vel !== 3'd4 || chg !== 0) begin
      errors++; $display("FAIL both_cancel got vel=%0d pulses=%0d want 4,0", vel, chg);
    end
    checks++;
  endtask

  task automatic test_clr_during_hold();
    int k = 0;
    int chg_at[$];
    int chg_val[$];
    inc_vel = 1;
    while (vel !== 3'd5 && k < 60) begin tick_cycle(); k++; end
    if (vel !== 3'd5) begin errors++; $display("FAIL clr_hold_setup got vel=%0d want 5", vel); end
    checks++;
    for (int j = 0; j < 5; j++) tick_cycle();
    clr = 1;
    tick_cycle();
    clr = 0;
    if (vel !== 3'd2 || vel_changed !== 1'b0 || move_tick !== 1'b0) begin
      errors++; $display("FAIL clr_hold_reset got vel=%0d chg=%b tick=%b want 2,0,0", vel, vel_changed, move_tick);
    end
    checks++;
    for (int j = 1; j <= 70; j++) begin
      tick_cycle();
      if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
        errors++; $display("FAIL clr_hold cyc=%0d got vel/chg/lim/tick=%b want %b", cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
      end
      checks++;
      if (vel_changed) begin chg_at.push_back(j); chg_val.push_back(int'(vel)); end
    end
    // 2 sync edges + 4 debounce edges, then vel lands one edge later.
    if (chg_at.size() < 2 || chg_at[0] !== 7 || chg_val[0] !== 3 || chg_at[1] !== 27 || chg_val[1] !== 4) begin
      errors++; $display("FAIL clr_hold_repress got %0d changes first@%0d want 3@7 then 4@27", chg_at.size(),
                         (chg_at.size() > 0) ? chg_at[0] : -1);
    end
    checks++;
    inc_vel = 0;
    for (int j = 0; j < 30; j++) tick_cycle();
  endtask

  task automatic test_random();
    int kind, len, gap;
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 45);
      gap  = $urandom_range(5, 40);
      for (int k = 0; k < len + gap; k++) begin
        inc_vel = (k < len) && (kind == 1 || kind == 3);
        dec_vel = (k < len) && (kind == 2 || kind == 3);
        tick_cycle();
        if ({vel, vel_changed, at_limit, move_tick} !== m_out) begin
          errors++; $display("FAIL random it=%0d cyc=%0d got vel/chg/lim/tick=%b want %b", it, cyc, {vel, vel_changed, at_limit, move_tick}, m_out);
        end
        checks++;
      end
    end
    inc_vel = 0; dec_vel = 0;
  endtask

  initial begin
    clr = 1; inc_vel = 0; dec_vel = 0;
    test_reset();
    test_short_press();
    test_hold_inc();
    test_dec_to_zero();
    test_both_buttons();
    test_clr_during_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
